// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl
//
// Execution controller for the MIPS pipeline. Converts debug-unit commands
// (RUN, STEP, STOP, CLEAR) into the pipeline-wide enable and clear strobes
// that drive the PC and stage registers. Detects program end when the halt
// instruction retires, keeps a saturating count of enabled cycles and runs an
// optional watchdog while in RUN.
//
// Parameters:
//   CNT_SIZE      width of the executed-cycle counter and the timeout value
//   CLEAR_CYCLES  cycles o_clear stays high per CLEAR command (1..15)
//   TIMEOUT       enabled-cycle limit for RUN; 0 disables the watchdog
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_cmd_valid    command strobe from the debug unit
//   i_cmd          command code: 0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 CLEAR
//   o_cmd_ready    a command presented this cycle will be consumed
//   i_halt_wb      halt instruction in writeback (qualified by o_enable)
//   o_enable       pipeline/PC enable
//   o_clear        pipeline/PC clear strobe
//   o_done         program ended (halt retired or watchdog expired)
//   o_timeout      program end was caused by the watchdog
//   o_cmd_err      one-cycle pulse: an accepted command was ignored
//   o_state        IDLE=0, RUN=1, STEP=2, CLEAR=3, END=4
//   o_cycle_count  enabled cycles since the last clear/reset (saturating)
//
// Every output is a flop: the combinational block computes the next value of
// each output and the sequential block registers them all.
// ---------------------------------------------------------------------------
module exec_ctrl #(
    parameter int unsigned CNT_SIZE     = 32,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [2:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic                i_halt_wb,
    output logic                o_enable,
    output logic                o_clear,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_cmd_err,
    output logic [2:0]          o_state,
    output logic [CNT_SIZE-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_END   = 3'd4
    } state_t;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_STEP  = 3'd2;
    localparam logic [2:0] CMD_STOP  = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    localparam logic [CNT_SIZE-1:0] CNT_ONE     = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] TIMEOUT_VAL = CNT_SIZE'(TIMEOUT);
    localparam bit                  WDOG_EN     = (TIMEOUT != 0);
    // The clear counter loads "cycles remaining after this one", so the
    // state is left on the edge where it reads zero.
    localparam logic [3:0]          CLR_LAST    = 4'(CLEAR_CYCLES - 1);

    state_t                state_q,   state_d;
    logic                  enable_q,  enable_d;
    logic                  clear_q,   clear_d;
    logic                  done_q,    done_d;
    logic                  timeout_q, timeout_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  ready_q,   ready_d;
    logic [CNT_SIZE-1:0]   cnt_q,     cnt_d;
    logic [3:0]            clr_cnt_q, clr_cnt_d;

    logic                  accept;
    logic                  halt_ret;
    logic                  go_clear;
    logic [CNT_SIZE-1:0]   cnt_inc;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cmd_err_q <= 1'b0;
            ready_q   <= 1'b1;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cmd_err_q <= cmd_err_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        accept    = i_cmd_valid && ready_q;
        halt_ret  = i_halt_wb && enable_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

        state_d   = state_q;
        cnt_d     = enable_q ? cnt_inc : cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cmd_err_d = 1'b0;
        clr_cnt_d = clr_cnt_q;
        go_clear  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP:   ;
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: go_clear = 1'b1;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end

            ST_RUN: begin
                // Halt beats the watchdog, which beats any command. A command
                // arriving on a halt/timeout edge is consumed silently.
                if (halt_ret) begin
                    state_d = ST_END;
                    done_d  = 1'b1;
                end else if (WDOG_EN && (cnt_inc == TIMEOUT_VAL)) begin
                    state_d   = ST_END;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (accept) begin
                    case (i_cmd)
                        CMD_NOP:   ;
                        CMD_STOP:  state_d = ST_IDLE;
                        CMD_CLEAR: go_clear = 1'b1;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end

            ST_STEP: begin
                if (halt_ret) begin
                    state_d = ST_END;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                if (clr_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q - 4'd1;
                end
            end

            ST_END: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP:   ;
                        CMD_CLEAR: go_clear = 1'b1;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering CLEAR zeroes the status so the first clear cycle already
        // shows a clean count; this overrides the RUN-cycle increment above.
        if (go_clear) begin
            state_d   = ST_CLEAR;
            cnt_d     = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            clr_cnt_d = CLR_LAST;
        end

        enable_d = (state_d == ST_RUN) || (state_d == ST_STEP);
        clear_d  = (state_d == ST_CLEAR);
        ready_d  = !((state_d == ST_STEP) || (state_d == ST_CLEAR));
    end

    assign o_state       = state_q;
    assign o_enable      = enable_q;
    assign o_clear       = clear_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_cmd_err     = cmd_err_q;
    assign o_cmd_ready   = ready_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl
//
// Self-checking bench for exec_ctrl. A behavioural model tracks the mode,
// counter and status flags with plain integers and is compared against every
// DUT output one time unit after each clock edge and after reset assertion.
// Directed sequences pin known literal values; a random phase follows.
// ---------------------------------------------------------------------------
module tb_exec_ctrl;

    localparam int CNT_SIZE     = 6;
    localparam int CLEAR_CYCLES = 2;
    localparam int TIMEOUT      = 20;
    localparam int CNT_MAX      = (1 << CNT_SIZE) - 1;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_RUN   = 3'd1;
    localparam logic [2:0] C_STEP  = 3'd2;
    localparam logic [2:0] C_STOP  = 3'd3;
    localparam logic [2:0] C_CLEAR = 3'd4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic [2:0]          cmd = 3'd0;
    logic                halt_wb = 1'b0;
    logic                cmd_ready;
    logic                enable;
    logic                clear;
    logic                done;
    logic                timeout;
    logic                cmd_err;
    logic [2:0]          state;
    logic [CNT_SIZE-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    exec_ctrl #(
        .CNT_SIZE    (CNT_SIZE),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .o_cmd_ready  (cmd_ready),
        .i_halt_wb    (halt_wb),
        .o_enable     (enable),
        .o_clear      (clear),
        .o_done       (done),
        .o_timeout    (timeout),
        .o_cmd_err    (cmd_err),
        .o_state      (state),
        .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: mode 0 IDLE, 1 RUN, 2 STEP, 3 CLEAR, 4 END
    // -----------------------------------------------------------------------
    int m_mode       = 0;
    int m_cnt        = 0;
    int m_clear_left = 0;
    bit m_done       = 0;
    bit m_to         = 0;
    bit m_err        = 0;

    function automatic bit m_ready(input int mode);
        return !(mode == 2 || mode == 3);
    endfunction

    function automatic bit m_enabled(input int mode);
        return (mode == 1 || mode == 2);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_clear_left = 0;
        m_done = 0; m_to = 0; m_err = 0;
    endtask

    task automatic model_enter_clear();
        m_mode = 3; m_cnt = 0; m_done = 0; m_to = 0;
        m_clear_left = CLEAR_CYCLES;
    endtask

    task automatic model_step(input bit v, input logic [2:0] c, input bit h);
        bit acc;
        int mode;
        acc  = v && m_ready(m_mode);
        mode = m_mode;
        m_err = 0;
        if (m_enabled(mode) && m_cnt < CNT_MAX) m_cnt++;
        case (mode)
            0: if (acc) begin
                if (c == C_RUN) m_mode = 1;
                else if (c == C_STEP) m_mode = 2;
                else if (c == C_CLEAR) model_enter_clear();
                else if (c != C_NOP) m_err = 1;
            end
            1: begin
                if (h) begin
                    m_mode = 4; m_done = 1;
                end else if (TIMEOUT != 0 && m_cnt == TIMEOUT) begin
                    m_mode = 4; m_done = 1; m_to = 1;
                end else if (acc) begin
                    if (c == C_STOP) m_mode = 0;
                    else if (c == C_CLEAR) model_enter_clear();
                    else if (c != C_NOP) m_err = 1;
                end
            end
            2: begin
                if (h) begin
                    m_mode = 4; m_done = 1;
                end else begin
                    m_mode = 0;
                end
            end
            3: begin
                m_clear_left--;
                if (m_clear_left == 0) m_mode = 0;
            end
            default: if (acc) begin
                if (c == C_CLEAR) model_enter_clear();
                else if (c != C_NOP) m_err = 1;
            end
        endcase
    endtask

    // Single compare process
    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step(cmd_valid, cmd, halt_wb);
        #1;
        check("state",   int'(state),       m_mode);
        check("enable",  int'(enable),      int'(m_enabled(m_mode)));
        check("clear",   int'(clear),       int'(m_mode == 3));
        check("ready",   int'(cmd_ready),   int'(m_ready(m_mode)));
        check("done",    int'(done),        int'(m_done));
        check("timeout", int'(timeout),     int'(m_to));
        check("cmd_err", int'(cmd_err),     int'(m_err));
        check("count",   int'(cycle_count), m_cnt);
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (always entered and left at a falling edge)
    // -----------------------------------------------------------------------
    task automatic send(input logic [2:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd = c;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_ready_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = C_NOP;
    endtask

    task automatic do_clear();
        send(C_CLEAR);
        repeat (CLEAR_CYCLES) @(negedge clk);
    endtask

    bit rdy_seen;

    initial begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);

        // Reset mid-RUN
        send(C_RUN);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_count", int'(cycle_count), 0);
        check("rst_ready", int'(cmd_ready), 1);
        #1 reset = 1'b0;
        @(negedge clk);

        // RUN to halt in the 10th enabled cycle
        send(C_RUN);
        repeat (9) @(negedge clk);
        halt_wb = 1'b1;
        @(negedge clk);
        halt_wb = 1'b0;
        check("halt_count", int'(cycle_count), 10);
        check("halt_state", int'(state), 4);
        check("halt_done", int'(done), 1);
        check("halt_enable", int'(enable), 0);

        // CLEAR from END with a STEP held during the clear
        send(C_CLEAR);
        check("clr1_clear", int'(clear), 1);
        check("clr1_count", int'(cycle_count), 0);
        check("clr1_done", int'(done), 0);
        cmd_valid = 1'b1;
        cmd = C_STEP;
        @(negedge clk);
        check("clr2_clear", int'(clear), 1);
        check("clr2_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("clr_end_clear", int'(clear), 0);
        check("clr_end_state", int'(state), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = C_NOP;
        check("held_step_state", int'(state), 2);
        check("held_step_enable", int'(enable), 1);
        @(negedge clk);
        check("held_step_count", int'(cycle_count), 1);

        // Three more STEPs
        for (int i = 0; i < 3; i++) begin
            send(C_STEP);
            check("step_ready", int'(cmd_ready), 0);
            @(negedge clk);
            check("step_idle", int'(state), 0);
        end
        check("steps_count", int'(cycle_count), 4);

        // Watchdog expiry, then RUN in END
        do_clear();
        send(C_RUN);
        for (int i = 0; i < 40 && state != 3'd4; i++) @(negedge clk);
        check("wd_state", int'(state), 4);
        check("wd_timeout", int'(timeout), 1);
        check("wd_count", int'(cycle_count), 20);
        send(C_RUN);
        check("end_run_err", int'(cmd_err), 1);
        check("end_run_state", int'(state), 4);

        // STOP and halt on the same edge
        do_clear();
        send(C_RUN);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd = C_STOP; halt_wb = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = C_NOP; halt_wb = 1'b0;
        check("sim_state", int'(state), 4);
        check("sim_done", int'(done), 1);
        check("sim_err", int'(cmd_err), 0);

        // Reserved code and STOP in IDLE
        do_clear();
        send(3'd6);
        check("rsv_err", int'(cmd_err), 1);
        check("rsv_state", int'(state), 0);
        send(C_STOP);
        check("idle_stop_err", int'(cmd_err), 1);

        // Counter saturation: past TIMEOUT via STEPs, then RUN to all-ones
        for (int i = 0; i < 25; i++) send(C_STEP);
        @(negedge clk);
        send(C_RUN);
        repeat (50) @(negedge clk);
        check("sat_count", int'(cycle_count), CNT_MAX);
        check("sat_state", int'(state), 1);
        send(C_STOP);
        check("sat_stop_state", int'(state), 0);

        // Random phase
        rdy_seen = cmd_ready;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
                cmd_valid = 1'b0;
            end else if (!(cmd_valid && !rdy_seen)) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 9) < 7) cmd = 3'($urandom_range(0, 3));
                else cmd = 3'($urandom_range(4, 7));
            end
            halt_wb = ($urandom_range(0, 24) == 0);
            rdy_seen = cmd_ready;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        halt_wb = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Execution controller for the MIPS pipeline. It turns debug-unit commands (run, step, stop, clear) into the pipeline-wide enable and clear strobes that drive the PC and the stage registers. It also detects program end when the halt instruction retires, and keeps a saturating executed-cycle counter plus a run watchdog. It sits between the debug/UART unit and the pipeline top level.

Parameters:
CNT_SIZE, 32, width of the executed-cycle counter and of the timeout value
CLEAR_CYCLES, 2, number of cycles o_clear is held high per CLEAR command (1..15)
TIMEOUT, 0, cycle limit for RUN; 0 disables the watchdog

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_reset  in  1  reset, asynchronous, active-high
i_cmd_valid  in  1  command strobe from the debug unit
i_cmd  in  3  command code: 0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 CLEAR, 5-7 reserved
o_cmd_ready  out  1  controller can accept a command this cycle
i_halt_wb  in  1  halt instruction is in writeback this cycle (qualified by o_enable)
o_enable  out  1  pipeline/PC enable
o_clear  out  1  pipeline/PC clear strobe
o_done  out  1  program ended (halt retired or timeout)
o_timeout  out  1  END was reached via the watchdog
o_cmd_err  out  1  one-cycle pulse: an accepted command was ignored
o_state  out  3  current state: IDLE=0, RUN=1, STEP=2, CLEAR=3, END=4
o_cycle_count  out  CNT_SIZE  number of enabled cycles since the last clear/reset

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, o_cmd_ready=1, and o_enable, o_clear, o_done, o_timeout, o_cmd_err, o_cycle_count all 0. Reset takes effect immediately at any time, including mid-RUN or mid-CLEAR.
- Handshake: a command is accepted on an edge where i_cmd_valid && o_cmd_ready. o_cmd_ready=1 in IDLE, RUN and END; 0 in STEP and CLEAR. Commands presented while ready=0 are not consumed; the debug unit must hold them.
- An accepted NOP does nothing and produces no error. An accepted reserved code (5-7) produces an o_cmd_err pulse and no state change.
- Latency: the edge that accepts RUN or STEP sets o_enable=1 for the following cycle. The edge that accepts CLEAR sets o_clear=1 for the following cycle.
- IDLE:
  - o_enable=0.
  - RUN -> RUN; STEP -> STEP; CLEAR -> CLEAR.
  - STOP -> o_cmd_err pulse, stays in IDLE.
- RUN:
  - o_enable=1 every cycle; o_cycle_count increments on each edge where o_enable=1.
  - i_halt_wb=1 -> END, with o_enable=0 from the next cycle and o_done=1.
  - Watchdog: if TIMEOUT!=0 and the incremented count equals TIMEOUT -> END with o_timeout=1.
  - STOP -> IDLE; o_enable=0 next cycle.
  - CLEAR -> CLEAR.
  - RUN or STEP -> o_cmd_err pulse, stays in RUN.
  - Priority on the same edge: halt > timeout > command.
- STEP:
  - o_enable=1 for exactly one cycle and the count increments by 1.
  - If i_halt_wb=1 in that cycle -> END; otherwise -> IDLE.
- CLEAR:
  - o_clear=1 and o_enable=0 for CLEAR_CYCLES consecutive cycles, counted by an internal 4-bit counter.
  - o_cycle_count, o_done and o_timeout are zeroed on the first CLEAR cycle.
  - After the last CLEAR cycle -> IDLE.
- END:
  - o_enable=0; o_done is held (and o_timeout if set).
  - CLEAR -> CLEAR.
  - RUN, STEP or STOP -> o_cmd_err pulse, stays in END.
- i_halt_wb is ignored in IDLE, CLEAR and END.
- o_cycle_count saturates at all-ones; it never wraps.
- Invalid state encodings recover to IDLE on the next edge.

Test Plan:
- Reset mid-RUN: RUN accepted, 5 cycles elapse, then pulse i_reset -> o_state=0, o_enable=0, o_cycle_count=0 immediately; o_cmd_ready=1.
- RUN to halt: RUN at edge 0, i_halt_wb=1 in the 10th enabled cycle -> o_cycle_count=10, o_state=4, o_done=1; o_enable low from the next cycle.
- Three STEPs: three STEP commands, each issued when ready -> o_enable high exactly 3 cycles total, count=3, state returns to IDLE each time; ready=0 during each STEP cycle.
- Watchdog: TIMEOUT=20, RUN with i_halt_wb held 0 -> END after 20 enabled cycles, o_timeout=1, count=20. A following RUN -> o_cmd_err pulse, state stays END.
- Simultaneous events: during RUN, STOP and i_halt_wb=1 on the same edge -> END, o_done=1, no o_cmd_err.
- CLEAR from END: CLEAR with CLEAR_CYCLES=2 -> o_clear high exactly 2 cycles; count, o_done and o_timeout are 0; then IDLE. A STEP presented during CLEAR is held, then accepted in IDLE.
